// File: rtl/nand_array_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters, the shared NAND-array
// arbiter and the result consumer. master = requester/consumer side,
// slave = arbiter side.
interface nand_array_arbiter_if #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WIDTH-1:0]         rsp_data;
  logic [ID_W-1:0]          rsp_id;
  logic                     busy;
  logic [CNT_W-1:0]         op_count;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy, op_count
  );
endinterface

// File: rtl/nand_array_arbiter.sv
// Round-robin arbiter in front of a WIDTH-bit bitwise NAND array.
// One operation at a time: IDLE accepts a winner's operands, EXEC computes
// ~(a & b), RESP holds the result until the consumer takes it.
module nand_array_arbiter #(
  parameter int WIDTH   = 4,
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nand_array_arbiter_if.slave   bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_reg;
  logic [ID_W-1:0]   rr_ptr_reg;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic [ID_W-1:0]   id_reg;
  logic              rsp_valid_reg;
  logic [WIDTH-1:0]  rsp_data_reg;
  logic [ID_W-1:0]   rsp_id_reg;
  logic              busy_reg;
  logic [CNT_W-1:0]  op_count_reg;

  logic [ID_W-1:0]   winner;
  logic              found;
  logic [ID_W:0]     cand;
  logic              grant_en;
  logic [ID_W-1:0]   rr_next;
  logic [WIDTH-1:0]  a_sel;
  logic [WIDTH-1:0]  b_sel;

  // Per-requester operand slices, unpacked so the winner can index them.
  logic [WIDTH-1:0]  a_arr [NUM_REQ];
  logic [WIDTH-1:0]  b_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign a_arr[gi] = bus.req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = bus.req_b[gi*WIDTH +: WIDTH];
      // Grant is one-hot on the winner, only while IDLE and someone is asking.
      assign bus.req_ready[gi] = grant_en && (winner == ID_W'(gi));
    end
  endgenerate

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_reg} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!found && bus.req_valid[cand[ID_W-1:0]]) begin
        winner = cand[ID_W-1:0];
        found  = 1'b1;
      end
    end
  end

  assign grant_en = (state_reg == IDLE) && found;
  assign rr_next  = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
  assign a_sel    = a_arr[winner];
  assign b_sel    = b_arr[winner];

  // Operation sequencer; all outputs except req_ready are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      id_reg        <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_id_reg    <= '0;
      busy_reg      <= 1'b0;
      op_count_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (found) begin
            a_reg      <= a_sel;
            b_reg      <= b_sel;
            id_reg     <= winner;
            rr_ptr_reg <= rr_next;
            state_reg  <= EXEC;
            busy_reg   <= 1'b1;
          end
        end
        EXEC: begin
          rsp_data_reg  <= ~(a_reg & b_reg);
          rsp_id_reg    <= id_reg;
          rsp_valid_reg <= 1'b1;
          state_reg     <= RESP;
        end
        RESP: begin
          // Result and id stay frozen until the consumer accepts.
          if (bus.rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            op_count_reg  <= op_count_reg + CNT_W'(1);
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          rsp_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_data  = rsp_data_reg;
  assign bus.rsp_id    = rsp_id_reg;
  assign bus.busy      = busy_reg;
  assign bus.op_count  = op_count_reg;

endmodule

// File: tb/tb_nand_array_arbiter.sv
// Bench for nand_array_arbiter: vector table, hand-written corner sequences
// and a randomized run against a transaction-level reference model.
module tb_nand_array_arbiter;
  localparam int WIDTH   = 4;
  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 8;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  nand_array_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) bus ();

  nand_array_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_rdy;
    logic [3:0] exp_data;
    logic [1:0] exp_id;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'(0));
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(0));
    check({tag, "_rsp_data"},  32'(bus.rsp_data),  32'(0));
    check({tag, "_rsp_id"},    32'(bus.rsp_id),    32'(0));
    check({tag, "_busy"},      32'(bus.busy),      32'(0));
    check({tag, "_op_count"},  32'(bus.op_count),  32'(0));
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    check_reset_state("reset");
    rst_n = 1'b1;
  endtask

  // One complete operation with rsp_ready held high (including during EXEC).
  task automatic run_op(input logic [3:0] vmask, input logic [3:0] exp_rdy,
                        input logic [3:0] exp_data, input logic [1:0] exp_id,
                        input string tag, input bit verbose);
    bus.req_valid = vmask;
    bus.rsp_ready = 1'b1;
    #1;
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'(exp_rdy));
    tick();
    bus.req_valid = '0;
    check({tag, "_exec_busy"},  32'(bus.busy),      32'(1));
    check({tag, "_exec_valid"}, 32'(bus.rsp_valid), 32'(0));
    tick();
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(1));
    check({tag, "_rsp_data"},  32'(bus.rsp_data),  32'(exp_data));
    check({tag, "_rsp_id"},    32'(bus.rsp_id),    32'(exp_id));
    if (verbose)
      $display("op %s: req_valid=%b grant=%b rsp_data=%h rsp_id=%0d",
               tag, vmask, exp_rdy, bus.rsp_data, bus.rsp_id);
    tick();
    check({tag, "_done_valid"}, 32'(bus.rsp_valid), 32'(0));
    check({tag, "_done_busy"},  32'(bus.busy),      32'(0));
  endtask

  // Reference model state (transaction level).
  int         m_rr;
  int         m_count;
  bit         m_pending;
  int         m_age;
  logic [3:0] m_data;
  int         m_id;
  bit         has_op [NUM_REQ];
  logic [3:0] op_a [NUM_REQ];
  logic [3:0] op_b [NUM_REQ];

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  vmask;
    logic [3:0]  rdy_seen;
    logic [15:0] pa;
    logic [15:0] pb;
    logic [7:0]  ab;
    logic        rr_in;
    int          win;

    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    // Asynchronous reset: outputs are zero before any clock edge.
    #3;
    check_reset_state("rst_async");
    tick();
    tick();
    check_reset_state("rst_hold");
    rst_n = 1'b1;

    // Operands: a0=C b0=A -> 7, a1=F b1=0 -> F, a2=F b2=F -> 0, a3=6 b3=3 -> D
    bus.req_a = 16'h6FFC;
    bus.req_b = 16'h3F0A;
    tbl[0] = '{4'b0001, 4'b0001, 4'h7, 2'd0};
    tbl[1] = '{4'b1111, 4'b0010, 4'hF, 2'd1};
    tbl[2] = '{4'b1111, 4'b0100, 4'h0, 2'd2};
    tbl[3] = '{4'b0101, 4'b0001, 4'h7, 2'd0};  // rr_ptr=3, skips 3, wraps
    tbl[4] = '{4'b0101, 4'b0100, 4'h0, 2'd2};
    tbl[5] = '{4'b1000, 4'b1000, 4'hD, 2'd3};  // rr_ptr wraps to 0
    tbl[6] = '{4'b1111, 4'b0001, 4'h7, 2'd0};
    tbl[7] = '{4'b0010, 4'b0010, 4'hF, 2'd1};
    tbl[8] = '{4'b0011, 4'b0001, 4'h7, 2'd0};
    tbl[9] = '{4'b1100, 4'b0100, 4'h0, 2'd2};
    for (int i = 0; i < 10; i++) begin
      run_op(tbl[i].valid, tbl[i].exp_rdy, tbl[i].exp_data, tbl[i].exp_id,
             $sformatf("tbl%0d", i), 1'b1);
    end
    check("tbl_op_count", 32'(bus.op_count), 32'(10));

    // Back-pressure: rr_ptr=3, requester 0 wins, result held 10 cycles.
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b0;
    #1;
    check("bp_grant", 32'(bus.req_ready), 32'(4'b0001));
    tick();
    bus.req_valid = 4'b1110;
    tick();
    for (int c = 0; c < 10; c++) begin
      check("bp_rsp_valid", 32'(bus.rsp_valid), 32'(1));
      check("bp_rsp_data",  32'(bus.rsp_data),  32'(4'h7));
      check("bp_rsp_id",    32'(bus.rsp_id),    32'(0));
      check("bp_req_ready", 32'(bus.req_ready), 32'(0));
      check("bp_busy",      32'(bus.busy),      32'(1));
      tick();
    end
    bus.rsp_ready = 1'b1;
    tick();
    check("bp_release_busy",  32'(bus.busy),      32'(0));
    check("bp_release_valid", 32'(bus.rsp_valid), 32'(0));
    check("bp_release_count", 32'(bus.op_count), 32'(11));
    #1;
    check("bp_waiting_grant", 32'(bus.req_ready), 32'(4'b0010));
    $display("op bp: held 10 cycles, released, op_count=%0d", bus.op_count);
    bus.req_valid = '0;  // withdraw before the edge: no transfer
    tick();
    check("bp_withdraw_busy", 32'(bus.busy), 32'(0));

    // Reset during EXEC: operation discarded, rr_ptr back to 0.
    bus.req_valid = 4'b0100;
    #1;
    check("rmid_grant", 32'(bus.req_ready), 32'(4'b0100));
    tick();
    bus.req_valid = '0;
    check("rmid_exec_busy", 32'(bus.busy), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_state("rmid");
    tick();
    tick();
    check_reset_state("rmid_hold");
    rst_n = 1'b1;
    tick();
    check("rmid_no_rsp", 32'(bus.rsp_valid), 32'(0));
    $display("op rmid: reset during EXEC, no response");

    // Round robin with all valid held: grants 0,1,2,3,0, one per 3 cycles.
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      #1;
      check("rr_req_ready", 32'(bus.req_ready),
            (c % 3 == 0) ? (32'(1) << ((c / 3) % 4)) : 32'(0));
      tick();
      if (c % 3 == 1)
        $display("op rr%0d: grant=%0d", c / 3, (c / 3) % 4);
    end
    bus.req_valid = '0;
    check("rr_op_count", 32'(bus.op_count), 32'(5));

    // Exhaustive a,b through requester 2; 256 ops wrap op_count to 0.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      ab = 8'(i);
      pa = 16'($urandom);
      pb = 16'($urandom);
      pa[11:8] = ab[7:4];
      pb[11:8] = ab[3:0];
      bus.req_a = pa;
      bus.req_b = pb;
      run_op(4'b0100, 4'b0100, ~(ab[7:4] & ab[3:0]), 2'd2, "exh", 1'b0);
      if (i == 254) check("wrap_count_max", 32'(bus.op_count), 32'(255));
    end
    check("wrap_count_zero", 32'(bus.op_count), 32'(0));
    $display("op exh: 256 ops via requester 2, op_count=%0d", bus.op_count);

    // Randomized traffic against the reference model.
    do_reset();
    m_rr = 0; m_count = 0; m_pending = 1'b0; m_age = 0; m_data = '0; m_id = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      has_op[i] = 1'b0;
      op_a[i]   = '0;
      op_b[i]   = '0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!has_op[i] && $urandom_range(3) == 0) begin
          has_op[i] = 1'b1;
          op_a[i]   = 4'($urandom);
          op_b[i]   = 4'($urandom);
        end
        vmask[i]     = has_op[i] && ($urandom_range(7) != 0);
        pa[i*4 +: 4] = has_op[i] ? op_a[i] : 4'($urandom);
        pb[i*4 +: 4] = has_op[i] ? op_b[i] : 4'($urandom);
      end
      rr_in         = ($urandom_range(2) != 0);
      bus.req_valid = vmask;
      bus.req_a     = pa;
      bus.req_b     = pb;
      bus.rsp_ready = rr_in;
      #1;
      win = -1;
      if (!m_pending) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          int idx;
          idx = (m_rr + k) % NUM_REQ;
          if (win < 0 && vmask[idx]) win = idx;
        end
      end
      check("rnd_req_ready", 32'(bus.req_ready), (win >= 0) ? (32'(1) << win) : 32'(0));
      rdy_seen = bus.req_ready;
      tick();
      if (!m_pending) begin
        if (win >= 0) begin
          m_pending = 1'b1;
          m_age     = 0;
          m_data    = ~(op_a[win] & op_b[win]);
          m_id      = win;
          m_rr      = (win + 1) % NUM_REQ;
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (rr_in) begin
        m_pending = 1'b0;
        m_count   = (m_count + 1) % 256;
        $display("op rnd: id=%0d rsp_data=%h op_count=%0d", m_id, m_data, m_count);
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (rdy_seen[i]) has_op[i] = 1'b0;
      check("rnd_busy",      32'(bus.busy),      32'(m_pending));
      check("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(m_pending && m_age == 1));
      check("rnd_op_count",  32'(bus.op_count),  32'(m_count));
      if (m_pending && m_age == 1) begin
        check("rnd_rsp_data", 32'(bus.rsp_data), 32'(m_data));
        check("rnd_rsp_id",   32'(bus.rsp_id),   32'(m_id));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
